elvm_core: RTL and testbench
============================

ELVM_CORE -- requirements
Module: elvm_core

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, register and data-memory word width in bits (8..32).
REQ-002 The block SHALL have parameter DMEM_AW, default 8, data-memory address width; depth 2^DMEM_AW words.
REQ-003 The block SHALL have parameter IMEM_AW, default 8, program-counter width; program space 2^IMEM_AW words.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  execute enable; low freezes all architectural state.
REQ-007 imem_addr  output  IMEM_AW  program counter (PC), drives external instruction ROM.
REQ-008 imem_data  input  32  instruction at imem_addr, combinational (same-cycle) read.
REQ-009 out_data  output  8  character for putc, low 8 bits of source register.
REQ-010 out_valid  output  1  out_data valid; held until accepted.
REQ-011 out_ready  input  1  sink (UART sender) accepts when out_valid and out_ready both high.
REQ-012 halted  output  1  high once exit has executed.

Function
REQ-013 Instruction fields SHALL be: [31:27] op, [26] imm_sel, [25:23] rd, [22:20] rs, [19:0] imm; src = imm_sel ? imm truncated/zero-extended to DATA_W : R[rs].
REQ-014 Register file SHALL be 8 registers R0..R7 of DATA_W bits (R0-R5 = A,B,C,D,SP,BP; R6,R7 general).
REQ-015 FSM states SHALL be RUN, WAIT_OUT, HALT; with en high, RUN executes one instruction per cycle.
REQ-016 op 0 mov: R[rd] <= src; op 1 add: R[rd] <= (R[rd]+src) mod 2^DATA_W; op 2 sub: R[rd] <= (R[rd]-src) mod 2^DATA_W.
REQ-017 op 3 load: R[rd] <= DMEM[src[DMEM_AW-1:0]]; op 4 store: DMEM[src[DMEM_AW-1:0]] <= R[rd].
REQ-018 ops 8-13 eq,ne,lt,gt,le,ge: R[rd] <= 1 if (R[rd] cmp src) else 0; comparisons unsigned.
REQ-019 ops 14-19 jeq,jne,jlt,jgt,jle,jge: if (R[rd] cmp R[rs]) PC <= imm[IMEM_AW-1:0], else PC <= PC+1; imm_sel ignored.
REQ-020 op 20 jmp: PC <= imm[IMEM_AW-1:0] unconditionally.
REQ-021 op 5 putc: out_data <= R[rd][7:0], out_valid <= 1, next state WAIT_OUT; PC not advanced.
REQ-022 In WAIT_OUT, the cycle out_ready is high: out_valid <= 0, PC <= PC+1, next state RUN; out_data SHALL stay stable while out_valid is high.
REQ-023 op 6 exit: halted <= 1, state HALT; PC, registers and memory frozen until reset.
REQ-024 All other opcodes SHALL act as no-op with PC <= PC+1.
REQ-025 Non-jump PC increment SHALL wrap from 2^IMEM_AW-1 to 0.
REQ-026 en low SHALL block every register, memory, PC and state update; an asserted out_valid SHALL remain asserted and a handshake in WAIT_OUT SHALL complete only when en is high.
REQ-027 Writes to R[rd] take effect next cycle; an instruction reading a register SHALL see the value written by the preceding instruction.

Reset
REQ-028 While rst is low: PC=0, R0..R7=0, out_valid=0, out_data=0, halted=0, state RUN, regardless of clk.
REQ-029 Reset asserted in WAIT_OUT or HALT SHALL drop out_valid/halted immediately; DMEM contents are not reset (undefined until written).
REQ-030 After rst deasserts, the first instruction executed SHALL be the one at address 0 on the first rising clk with en high.

Verification
REQ-031 mov A,72; putc A; exit with out_ready=1 -> out_data=0x48, out_valid high exactly one cycle, then halted=1, PC stays 2.
REQ-032 putc with out_ready low for 5 cycles -> out_valid high 6 cycles, out_data constant, PC constant until the accept cycle.
REQ-033 DATA_W=8: mov A,250; add A,10 -> A=4; sub A,5 -> A=255.
REQ-034 store B(=7) at 0x10; load C from 0x10 -> C=7; lt C,8 (imm) -> C=1; jeq C,D(=1) to 0x20 -> PC=0x20.
REQ-035 IMEM_AW=4: no-op at PC=15 -> PC=0; jne with equal operands -> PC+1.
REQ-036 rst pulsed low mid-WAIT_OUT (out_ready low) -> out_valid=0 asynchronously, PC=0, registers 0; execution restarts at 0.

Source files
------------

// File: rtl/elvm_core.sv
// elvm_core: small ELVM-style register machine.
// Eight DATA_W registers, a private data memory, an external combinational
// instruction ROM addressed by the PC, and a putc output with a
// valid/ready handshake. One instruction per enabled cycle in RUN.
module elvm_core #(
  parameter int DATA_W  = 16,
  parameter int DMEM_AW = 8,
  parameter int IMEM_AW = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_data,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               halted
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_WAIT_OUT = 2'd1;
  localparam logic [1:0] ST_HALT     = 2'd2;

  // Architectural state
  logic [1:0]         r_state;
  logic [IMEM_AW-1:0] r_pc;
  logic [DATA_W-1:0]  r_regs [0:7];
  logic [DATA_W-1:0]  r_dmem [0:(2**DMEM_AW)-1];
  logic [7:0]         r_out_data;
  logic               r_out_valid;
  logic               r_halted;

  // Instruction fields and operands
  logic [4:0]         w_op;
  logic               w_imm_sel;
  logic [2:0]         w_rd;
  logic [2:0]         w_rs;
  logic [19:0]        w_imm;
  logic [31:0]        w_imm_ext;
  logic [DATA_W-1:0]  w_rd_val;
  logic [DATA_W-1:0]  w_rs_val;
  logic [DATA_W-1:0]  w_src;
  logic [DATA_W-1:0]  w_load_val;
  logic [DMEM_AW-1:0] w_dmem_addr;
  logic [IMEM_AW-1:0] w_pc_inc;
  logic [IMEM_AW-1:0] w_jmp_target;
  logic               w_set_true;
  logic               w_jmp_true;
  logic               w_unused;

  // Next-state values
  logic [1:0]         w_state_next;
  logic [IMEM_AW-1:0] w_pc_next;
  logic               w_reg_we;
  logic [DATA_W-1:0]  w_reg_wdata;
  logic               w_mem_we;
  logic [7:0]         w_out_data_next;
  logic               w_out_valid_next;
  logic               w_halted_next;

  // Unsigned relation selected by opcode: 8..13 set-on-compare, 14..19 branch.
  function automatic logic rel_true(input logic [4:0] op,
                                    input logic [DATA_W-1:0] a,
                                    input logic [DATA_W-1:0] b);
    logic res;
    case (op)
      5'd8,  5'd14: res = (a == b);
      5'd9,  5'd15: res = (a != b);
      5'd10, 5'd16: res = (a < b);
      5'd11, 5'd17: res = (a > b);
      5'd12, 5'd18: res = (a <= b);
      5'd13, 5'd19: res = (a >= b);
      default:      res = 1'b0;
    endcase
    return res;
  endfunction

  assign w_op         = imem_data[31:27];
  assign w_imm_sel    = imem_data[26];
  assign w_rd         = imem_data[25:23];
  assign w_rs         = imem_data[22:20];
  assign w_imm        = imem_data[19:0];
  // Immediate is zero-extended to 32 bits, then truncated to the datapath width.
  assign w_imm_ext    = {12'd0, w_imm};
  assign w_rd_val     = r_regs[w_rd];
  assign w_rs_val     = r_regs[w_rs];
  assign w_src        = w_imm_sel ? w_imm_ext[DATA_W-1:0] : w_rs_val;
  assign w_dmem_addr  = w_src[DMEM_AW-1:0];
  assign w_load_val   = r_dmem[w_dmem_addr];
  assign w_pc_inc     = r_pc + {{(IMEM_AW-1){1'b0}}, 1'b1};
  assign w_jmp_target = w_imm[IMEM_AW-1:0];
  assign w_set_true   = rel_true(w_op, w_rd_val, w_src);
  // Branches always compare two registers, whatever imm_sel says.
  assign w_jmp_true   = rel_true(w_op, w_rd_val, w_rs_val);
  assign w_unused     = ^w_imm_ext;

  // Decode the current instruction (RUN) or the pending handshake (WAIT_OUT).
  always_comb begin
    w_state_next     = r_state;
    w_pc_next        = r_pc;
    w_reg_we         = 1'b0;
    w_reg_wdata      = w_src;
    w_mem_we         = 1'b0;
    w_out_data_next  = r_out_data;
    w_out_valid_next = r_out_valid;
    w_halted_next    = r_halted;
    case (r_state)
      ST_RUN: begin
        w_pc_next = w_pc_inc;
        case (w_op)
          5'd0: begin
            w_reg_we    = 1'b1;
            w_reg_wdata = w_src;
          end
          5'd1: begin
            w_reg_we    = 1'b1;
            w_reg_wdata = w_rd_val + w_src;
          end
          5'd2: begin
            w_reg_we    = 1'b1;
            w_reg_wdata = w_rd_val - w_src;
          end
          5'd3: begin
            w_reg_we    = 1'b1;
            w_reg_wdata = w_load_val;
          end
          5'd4: begin
            w_mem_we = 1'b1;
          end
          5'd5: begin
            // PC stays on the putc until the sink accepts the character.
            w_out_data_next  = w_rd_val[7:0];
            w_out_valid_next = 1'b1;
            w_state_next     = ST_WAIT_OUT;
            w_pc_next        = r_pc;
          end
          5'd6: begin
            w_halted_next = 1'b1;
            w_state_next  = ST_HALT;
            w_pc_next     = r_pc;
          end
          5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13: begin
            w_reg_we    = 1'b1;
            w_reg_wdata = {{(DATA_W-1){1'b0}}, w_set_true};
          end
          5'd14, 5'd15, 5'd16, 5'd17, 5'd18, 5'd19: begin
            if (w_jmp_true) begin
              w_pc_next = w_jmp_target;
            end else begin
              w_pc_next = w_pc_inc;
            end
          end
          5'd20: begin
            w_pc_next = w_jmp_target;
          end
          default: begin
            w_pc_next = w_pc_inc;
          end
        endcase
      end
      ST_WAIT_OUT: begin
        if (out_ready) begin
          w_out_valid_next = 1'b0;
          w_pc_next        = w_pc_inc;
          w_state_next     = ST_RUN;
        end else begin
          w_out_valid_next = 1'b1;
          w_state_next     = ST_WAIT_OUT;
        end
      end
      ST_HALT: begin
        w_halted_next = 1'b1;
        w_state_next  = ST_HALT;
      end
      default: begin
        // Unreachable encoding: fall back to RUN without touching the PC.
        w_state_next = ST_RUN;
        w_pc_next    = r_pc;
      end
    endcase
  end

  // Architectural registers: async reset, otherwise frozen while en is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_RUN;
      r_pc        <= {IMEM_AW{1'b0}};
      r_out_data  <= 8'd0;
      r_out_valid <= 1'b0;
      r_halted    <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_regs[i] <= {DATA_W{1'b0}};
      end
    end else if (en) begin
      r_state     <= w_state_next;
      r_pc        <= w_pc_next;
      r_out_data  <= w_out_data_next;
      r_out_valid <= w_out_valid_next;
      r_halted    <= w_halted_next;
      if (w_reg_we) begin
        r_regs[w_rd] <= w_reg_wdata;
      end else begin
        r_regs[w_rd] <= r_regs[w_rd];
      end
    end else begin
      r_state     <= r_state;
      r_pc        <= r_pc;
      r_out_data  <= r_out_data;
      r_out_valid <= r_out_valid;
      r_halted    <= r_halted;
    end
  end

  // Data memory write port; contents survive reset, and no store lands while reset is held.
  always_ff @(posedge clk) begin
    if (rst && en && w_mem_we) begin
      r_dmem[w_dmem_addr] <= w_rd_val;
    end
  end

  assign imem_addr = r_pc;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign halted    = r_halted;

endmodule

// File: tb/tb_elvm_core.sv
// tb_elvm_core: directed checks of the putc handshake, arithmetic wrap,
// memory, compare/branch, PC wrap and async reset, followed by random
// programs checked cycle by cycle against an instruction-level interpreter.
module tb_elvm_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        halted;

  logic [3:0]  imem_addr8;
  logic [31:0] imem_data8;
  logic [7:0]  out_data8;
  logic        out_valid8;
  logic        out_ready8;
  logic        halted8;

  logic [31:0] rom  [0:255];
  logic [31:0] rom8 [0:15];

  int checks   = 0;
  int failures = 0;

  // Interpreter state for the default-parameter core
  logic [15:0] m_r   [0:7];
  logic [15:0] m_mem [0:255];
  logic [7:0]  m_pc;
  logic        m_busy;
  logic [7:0]  m_od;
  logic        m_halt;

  always #5 clk = ~clk;

  assign imem_data  = rom[imem_addr];
  assign imem_data8 = rom8[imem_addr8];

  elvm_core u_dut (
    .clk(clk), .rst(rst), .en(en),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .halted(halted)
  );

  elvm_core #(.DATA_W(8), .DMEM_AW(4), .IMEM_AW(4)) u_dut8 (
    .clk(clk), .rst(rst), .en(en),
    .imem_addr(imem_addr8), .imem_data(imem_data8),
    .out_data(out_data8), .out_valid(out_valid8), .out_ready(out_ready8),
    .halted(halted8)
  );

  function automatic logic [31:0] ins(input int op, input int isel, input int rd,
                                      input int rs, input int imm);
    return {op[4:0], isel[0], rd[2:0], rs[2:0], imm[19:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_reset();
    m_pc   = 8'd0;
    m_busy = 1'b0;
    m_od   = 8'd0;
    m_halt = 1'b0;
    for (int i = 0; i < 8; i++) m_r[i] = 16'd0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    m_reset();
  endtask

  function automatic logic rel(input int op, input logic [15:0] a, input logic [15:0] b);
    int c;
    c = (op - 8) % 6;
    case (c)
      0:       return a == b;
      1:       return a != b;
      2:       return a < b;
      3:       return a > b;
      4:       return a <= b;
      default: return a >= b;
    endcase
  endfunction

  // One clock of the instruction-level interpreter.
  task automatic m_step(input logic e, input logic rdy);
    logic [31:0] w;
    int op;
    int rd;
    int rs;
    logic [15:0] a;
    logic [15:0] s;
    if (!e || m_halt) return;
    if (m_busy) begin
      if (rdy) begin
        m_busy = 1'b0;
        m_pc   = m_pc + 8'd1;
      end
      return;
    end
    w  = rom[m_pc];
    op = int'(w[31:27]);
    rd = int'(w[25:23]);
    rs = int'(w[22:20]);
    a  = m_r[rd];
    s  = w[26] ? w[15:0] : m_r[rs];
    if (op == 5) begin
      m_od   = a[7:0];
      m_busy = 1'b1;
      return;
    end
    if (op == 6) begin
      m_halt = 1'b1;
      return;
    end
    if (op == 20 || (op >= 14 && op <= 19 && rel(op, a, m_r[rs]))) begin
      m_pc = w[7:0];
      return;
    end
    if (op == 0) m_r[rd] = s;
    if (op == 1) m_r[rd] = a + s;
    if (op == 2) m_r[rd] = a - s;
    if (op == 3) m_r[rd] = m_mem[s[7:0]];
    if (op == 4) m_mem[s[7:0]] = a;
    if (op >= 8 && op <= 13) m_r[rd] = rel(op, a, s) ? 16'd1 : 16'd0;
    m_pc = m_pc + 8'd1;
  endtask

  // Prologue initialises DMEM[0..7]; the body's loads/stores stay inside that window.
  task automatic gen_program();
    int k;
    for (int i = 0; i < 8; i++) begin
      rom[2*i]   = ins(0, 1, i, 0, $urandom_range(0, 20'hFFFFF));
      rom[2*i+1] = ins(4, 1, i, 0, i);
    end
    for (int adr = 16; adr < 256; adr++) begin
      k = $urandom_range(0, 22);
      if (k == 3 || k == 4)
        rom[adr] = ins(k, 1, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      else if (k == 6)
        rom[adr] = ($urandom_range(0, 15) == 0) ? ins(6, 0, 0, 0, 0) : ins(7, 0, 1, 2, 3);
      else if (k == 21)
        rom[adr] = ins(25, $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7), 5);
      else if (k == 22)
        rom[adr] = ins(5, 0, $urandom_range(0, 7), 0, 0);
      else
        rom[adr] = ins(k, $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7),
                       $urandom_range(0, 20'hFFFFF));
    end
  endtask

  task automatic wait_valid(input string tag, output logic [7:0] d);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_seen"}, {31'd0, out_valid}, 32'd1);
    d = out_data;
  endtask

  initial begin
    int vcnt;
    logic [7:0] vd;
    rst = 1'b0;
    en = 1'b0;
    out_ready = 1'b0;
    out_ready8 = 1'b1;
    for (int i = 0; i < 256; i++) rom[i] = ins(7, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) rom8[i] = ins(7, 0, 0, 0, 0);
    m_reset();

    // Reset values, before any clock edge
    #2;
    chk("rst_pc", {24'd0, imem_addr}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {24'd0, out_data}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);

    // mov A,72; putc A; exit with sink always ready
    rom[0] = ins(0, 1, 0, 0, 72);
    rom[1] = ins(5, 0, 0, 0, 0);
    rom[2] = ins(6, 0, 0, 0, 0);
    en = 1'b1;
    out_ready = 1'b1;
    do_reset();
    vcnt = 0;
    vd = 8'd0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid === 1'b1) begin
        vcnt++;
        vd = out_data;
      end
    end
    chk("hello_valid_cycles", vcnt, 32'd1);
    chk("hello_data", {24'd0, vd}, 32'h48);
    chk("hello_halted", {31'd0, halted}, 32'd1);
    chk("hello_pc", {24'd0, imem_addr}, 32'd2);

    // putc held off by the sink, plus an en-low cycle while ready is high
    rom[0] = ins(0, 1, 0, 0, 8'h41);
    out_ready = 1'b0;
    do_reset();
    tick();
    tick();
    vcnt = 0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_data", {24'd0, out_data}, 32'h41);
      chk("stall_pc", {24'd0, imem_addr}, 32'd1);
      if (out_valid === 1'b1) vcnt++;
      tick();
    end
    en = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("en_low_valid", {31'd0, out_valid}, 32'd1);
    chk("en_low_pc", {24'd0, imem_addr}, 32'd1);
    en = 1'b1;
    if (out_valid === 1'b1) vcnt++;
    tick();
    chk("stall_valid_cycles", vcnt, 32'd6);
    chk("accept_valid", {31'd0, out_valid}, 32'd0);
    chk("accept_pc", {24'd0, imem_addr}, 32'd2);

    // store / load / lt / jeq
    rom[0] = ins(0, 1, 1, 0, 7);
    rom[1] = ins(0, 1, 3, 0, 1);
    rom[2] = ins(4, 1, 1, 0, 8'h10);
    rom[3] = ins(3, 1, 2, 0, 8'h10);
    rom[4] = ins(5, 0, 2, 0, 0);
    rom[5] = ins(10, 1, 2, 0, 8);
    rom[6] = ins(5, 0, 2, 0, 0);
    rom[7] = ins(14, 0, 2, 3, 8'h20);
    rom[8'h20] = ins(6, 0, 0, 0, 0);
    do_reset();
    wait_valid("load", vd);
    chk("load_value", {24'd0, vd}, 32'd7);
    tick();
    chk("load_accept", {31'd0, out_valid}, 32'd0);
    wait_valid("lt", vd);
    chk("lt_value", {24'd0, vd}, 32'd1);
    tick();
    tick();
    chk("jeq_pc", {24'd0, imem_addr}, 32'h20);
    tick();
    chk("jeq_halted", {31'd0, halted}, 32'd1);

    // async reset in WAIT_OUT, then registers observed as zero
    rom[0] = ins(0, 1, 0, 0, 8'h55);
    rom[1] = ins(5, 0, 0, 0, 0);
    rom[2] = ins(6, 0, 0, 0, 0);
    out_ready = 1'b0;
    do_reset();
    tick();
    tick();
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_pc", {24'd0, imem_addr}, 32'd0);
    chk("async_rst_data", {24'd0, out_data}, 32'd0);
    rom[0] = ins(5, 0, 0, 0, 0);
    rom[1] = ins(6, 0, 0, 0, 0);
    tick();
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("restart_valid", {31'd0, out_valid}, 32'd1);
    chk("restart_reg_zero", {24'd0, out_data}, 32'd0);
    tick();
    tick();
    chk("restart_halted", {31'd0, halted}, 32'd1);
    chk("restart_pc", {24'd0, imem_addr}, 32'd1);

    // 8-bit datapath wrap and 4-bit PC wrap
    rom8[0] = ins(0, 1, 0, 0, 250);
    rom8[1] = ins(1, 1, 0, 0, 10);
    rom8[2] = ins(5, 0, 0, 0, 0);
    rom8[3] = ins(2, 1, 0, 0, 5);
    rom8[4] = ins(5, 0, 0, 0, 0);
    rom8[6] = ins(15, 0, 0, 0, 3);
    rom8[15] = ins(25, 0, 0, 0, 0);
    do_reset();
    tick();
    tick();
    tick();
    chk("w8_add_valid", {31'd0, out_valid8}, 32'd1);
    chk("w8_add_wrap", {24'd0, out_data8}, 32'd4);
    tick();
    tick();
    tick();
    chk("w8_sub_wrap", {24'd0, out_data8}, 32'd255);
    tick();
    tick();
    tick();
    chk("w8_jne_equal_pc", {28'd0, imem_addr8}, 32'd7);
    for (int i = 0; i < 8; i++) tick();
    chk("w8_pc_15", {28'd0, imem_addr8}, 32'd15);
    tick();
    chk("w8_pc_wrap", {28'd0, imem_addr8}, 32'd0);

    // Random programs against the interpreter
    for (int rnd = 0; rnd < 6; rnd++) begin
      gen_program();
      en = 1'b1;
      do_reset();
      for (int c = 0; c < 500; c++) begin
        en = ($urandom_range(0, 9) != 0);
        out_ready = $urandom_range(0, 1) != 0;
        @(posedge clk);
        m_step(en, out_ready);
        #1;
        chk("rnd_pc", {24'd0, imem_addr}, {24'd0, m_pc});
        chk("rnd_valid", {31'd0, out_valid}, {31'd0, m_busy});
        chk("rnd_data", {24'd0, out_data}, {24'd0, m_od});
        chk("rnd_halted", {31'd0, halted}, {31'd0, m_halt});
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
